keypad_scan_ctrl: RTL

//  Sequencer for the 4x4 motor-control keypad. Drives the row strobes, debounces columns and scans rows to locate one key.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_decode.sv | 43 ++++
 rtl/keypad_scan_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scan controller: FSM state codes, row constants and key codes.
package keypad_pkg;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StDebounce = 3'd1;
  localparam logic [2:0] StScan     = 3'd2;
  localparam logic [2:0] StRelease  = 3'd3;
  localparam logic [2:0] StCommit   = 3'd4;

  localparam logic [3:0] ROW_ALL   = 4'b1111;
  localparam logic [3:0] ROW_FIRST = 4'b0001;
  localparam logic [3:0] ROW_LAST  = 4'b1000;

  // Key codes are {row one-hot, column one-hot}
  localparam logic [7:0] KEY_1    = 8'h11;
  localparam logic [7:0] KEY_2    = 8'h12;
  localparam logic [7:0] KEY_3    = 8'h14;
  localparam logic [7:0] KEY_4    = 8'h21;
  localparam logic [7:0] KEY_5    = 8'h22;
  localparam logic [7:0] KEY_6    = 8'h24;
  localparam logic [7:0] KEY_7    = 8'h41;
  localparam logic [7:0] KEY_8    = 8'h42;
  localparam logic [7:0] KEY_9    = 8'h44;
  localparam logic [7:0] KEY_STAR = 8'h81;
  localparam logic [7:0] KEY_0    = 8'h82;
  localparam logic [7:0] KEY_HASH = 8'h84;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Maps a latched {row,col} key code to a speed setpoint or turn direction.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [7:0] code_i,
  output logic       hit_o,
  output logic       is_speed_o,
  output logic [3:0] speed_val_o,
  output logic       turn_val_o
);

  always_comb begin
    hit_o       = 1'b1;
    is_speed_o  = 1'b1;
    speed_val_o = 4'd0;
    turn_val_o  = 1'b0;
    case (code_i)
      KEY_1:    speed_val_o = 4'd1;
      KEY_2:    speed_val_o = 4'd2;
      KEY_3:    speed_val_o = 4'd3;
      KEY_4:    speed_val_o = 4'd4;
      KEY_5:    speed_val_o = 4'd5;
      KEY_6:    speed_val_o = 4'd6;
      KEY_7:    speed_val_o = 4'd7;
      KEY_8:    speed_val_o = 4'd8;
      KEY_9:    speed_val_o = 4'd9;
      KEY_0:    speed_val_o = 4'd0;
      KEY_STAR: begin
        is_speed_o = 1'b0;
        turn_val_o = 1'b1;
      end
      KEY_HASH: begin
        is_speed_o = 1'b0;
        turn_val_o = 1'b0;
      end
      default: begin
        hit_o      = 1'b0;
        is_speed_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad sequencer: debounces a press, scans rows to locate the key and commits on debounced
// release with a single-cycle key_valid strobe.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic [3:0] speed,
  output logic       turn,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DebLast    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       scan_row_q, scan_row_d;
  logic [3:0]       col_ref_q, col_ref_d;
  logic [7:0]       code_q, code_d;
  logic             invalid_q, invalid_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       speed_q, speed_d;
  logic             turn_q, turn_d;

  logic       dec_hit, dec_is_speed, dec_turn;
  logic [3:0] dec_speed;

  keypad_decode u_decode (
    .code_i      (code_q),
    .hit_o       (dec_hit),
    .is_speed_o  (dec_is_speed),
    .speed_val_o (dec_speed),
    .turn_val_o  (dec_turn)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    scan_row_d  = scan_row_q;
    col_ref_d   = col_ref_q;
    code_d      = code_q;
    invalid_d   = invalid_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    speed_d     = speed_q;
    turn_d      = turn_q;
    case (state_q)
      StIdle: begin
        if (col_in != 4'd0) begin
          state_d   = StDebounce;
          cnt_d     = '0;
          col_ref_d = col_in;
        end
      end
      StDebounce: begin
        if (col_in != col_ref_q) begin
          state_d = StIdle;
        end else if (cnt_q == DebLast) begin
          state_d    = StScan;
          scan_row_d = ROW_FIRST;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StScan: begin
        if (cnt_q != SettleLast) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (is_onehot4(col_in)) begin
            code_d    = {scan_row_q, col_in};
            invalid_d = 1'b0;
            state_d   = StRelease;
          end else if (col_in != 4'd0) begin
            invalid_d = 1'b1;
            state_d   = StRelease;
          end else if (scan_row_q == ROW_LAST) begin
            // Bounce lost before any row answered
            state_d = StIdle;
          end else begin
            scan_row_d = scan_row_q << 1;
          end
        end
      end
      StRelease: begin
        if (col_in != 4'd0) begin
          cnt_d = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StCommit;
          cnt_d   = '0;
          // Outputs are registered here so they change together with the strobe in StCommit
          if (dec_hit && !invalid_q) begin
            key_valid_d = 1'b1;
            key_code_d  = code_q;
            if (dec_is_speed) speed_d = dec_speed;
            else              turn_d  = dec_turn;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      scan_row_q  <= ROW_FIRST;
      col_ref_q   <= 4'd0;
      code_q      <= 8'd0;
      invalid_q   <= 1'b0;
      key_code_q  <= 8'd0;
      key_valid_q <= 1'b0;
      speed_q     <= 4'd0;
      turn_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scan_row_q  <= scan_row_d;
      col_ref_q   <= col_ref_d;
      code_q      <= code_d;
      invalid_q   <= invalid_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      speed_q     <= speed_d;
      turn_q      <= turn_d;
    end
  end

  assign row_out   = (state_q == StScan) ? scan_row_q : ROW_ALL;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign speed     = speed_q;
  assign turn      = turn_q;
  assign busy      = (state_q != StIdle);

endmodule
